// File: rtl/neo_frame_loader.sv
// Frame buffer feeding the NeoPixel strand controller: collects one RGB frame from a byte
// stream, replays it one colour per cycle over the load port, then requests a send.
module neo_frame_loader #(
    parameter int unsigned NUM_PIXELS = 5,
    parameter int unsigned PIX_W      = 3
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    input  logic             ready_to_load,
    input  logic             ready_to_send,
    output logic             load_color,
    output logic [1:0]       color_index,
    output logic [PIX_W-1:0] pixel_index,
    output logic [7:0]       color_level,
    output logic             send_it,
    output logic             frame_err,
    output logic [7:0]       frames_sent
);

    localparam int unsigned FrameBytes = 3 * NUM_PIXELS;
    localparam int unsigned PtrW       = $clog2(FrameBytes);

    typedef enum logic [1:0] {
        StFill = 2'b00,
        StLoad = 2'b01,
        StSend = 2'b10
    } state_e;

    state_e          state_q, state_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic            frame_err_q, frame_err_d;
    logic [7:0]      frames_sent_q, frames_sent_d;
    logic [7:0]      frame_buf [FrameBytes];

    logic            accept;
    logic            last_write;
    logic            last_read;
    logic            buf_we;
    logic [PtrW-1:0] buf_waddr;

    assign accept     = in_valid && in_ready;
    assign last_write = accept && !in_sof && (wr_ptr_q == PtrW'(FrameBytes - 1));
    assign last_read  = load_color && (rd_ptr_q == PtrW'(FrameBytes - 1));

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StFill;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; the unused encoding recovers to StFill
    always_comb begin
        state_d = state_q;
        case (state_q)
            StFill:  if (last_write)    state_d = StLoad;
            StLoad:  if (last_read)     state_d = StSend;
            StSend:  if (ready_to_send) state_d = StFill;
            default: state_d = StFill;
        endcase
    end

    // Handshake outputs follow the controller's ready inputs in the same cycle
    always_comb begin
        in_ready   = 1'b0;
        load_color = 1'b0;
        send_it    = 1'b0;
        case (state_q)
            StFill:  in_ready   = 1'b1;
            StLoad:  load_color = ready_to_load;
            StSend:  send_it    = ready_to_send;
            default: ;
        endcase
    end

    // Write side: an sof byte always restarts the frame at slot 0
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        frame_err_d = 1'b0;
        buf_we      = 1'b0;
        buf_waddr   = wr_ptr_q;
        if (accept) begin
            if (in_sof) begin
                buf_we      = 1'b1;
                buf_waddr   = '0;
                wr_ptr_d    = PtrW'(1);
                frame_err_d = (wr_ptr_q != '0);
            end else if (wr_ptr_q == '0) begin
                frame_err_d = 1'b1;
            end else begin
                buf_we   = 1'b1;
                wr_ptr_d = last_write ? '0 : wr_ptr_q + PtrW'(1);
            end
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        if (load_color) begin
            rd_ptr_d = last_read ? '0 : rd_ptr_q + PtrW'(1);
        end
        frames_sent_d = frames_sent_q + 8'(send_it);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            frame_err_q   <= 1'b0;
            frames_sent_q <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            frame_err_q   <= frame_err_d;
            frames_sent_q <= frames_sent_d;
        end
    end

    always_ff @(posedge clock) begin
        if (buf_we) begin
            frame_buf[buf_waddr] <= in_data;
        end
    end

    // Byte order is R,G,B per pixel; the controller codes G as 10 and B as 01
    always_comb begin
        color_index = 2'b00;
        pixel_index = '0;
        color_level = '0;
        if (state_q == StLoad) begin
            pixel_index = PIX_W'(rd_ptr_q / PtrW'(3));
            color_level = frame_buf[rd_ptr_q];
            case (rd_ptr_q % PtrW'(3))
                PtrW'(0): color_index = 2'b00;
                PtrW'(1): color_index = 2'b10;
                default:  color_index = 2'b01;
            endcase
        end
    end

    assign frame_err   = frame_err_q;
    assign frames_sent = frames_sent_q;

endmodule

// File: tb/tb_neo_frame_loader.sv
// Scoreboard bench for neo_frame_loader: a byte-queue frame model predicts loads, sends,
// frame errors and the send counter; a negedge monitor compares every cycle.
module tb_neo_frame_loader;

    localparam int NP = 5;
    localparam int PW = 3;
    localparam int FB = 3 * NP;

    typedef struct packed {
        logic [PW-1:0] pix;
        logic [1:0]    idx;
        logic [7:0]    lvl;
    } load_t;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_sof = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_ready;
    logic          ready_to_load = 1'b0;
    logic          ready_to_send = 1'b0;
    logic          load_color;
    logic [1:0]    color_index;
    logic [PW-1:0] pixel_index;
    logic [7:0]    color_level;
    logic          send_it;
    logic          frame_err;
    logic [7:0]    frames_sent;

    neo_frame_loader #(.NUM_PIXELS(NP), .PIX_W(PW)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_sof       (in_sof),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .ready_to_load(ready_to_load),
        .ready_to_send(ready_to_send),
        .load_color   (load_color),
        .color_index  (color_index),
        .pixel_index  (pixel_index),
        .color_level  (color_level),
        .send_it      (send_it),
        .frame_err    (frame_err),
        .frames_sent  (frames_sent)
    );

    always #10 clock = ~clock;

    int         checks = 0;
    int         passes = 0;
    load_t      exp_load[$];
    logic [7:0] exp_send[$];
    logic [7:0] mframe[$];
    int         err_pending = 0;
    int         model_count = 0;
    int         frames_total = 0;
    int         load_cnt = 0;
    int         rtl_mode = 0;
    int         rts_mode = 0;
    logic       pend = 1'b0;
    logic [7:0] pend_val = 8'h00;
    logic       loads_due, send_due, fill_due;
    load_t      mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [1:0] col_code(input int c);
        return (c == 0) ? 2'b00 : (c == 1) ? 2'b10 : 2'b01;
    endfunction

    // Reference model: a frame is the bytes since the last sof; FB of them make a frame
    function automatic void model_accept(input logic sof, input logic [7:0] d);
        if (sof) begin
            if (mframe.size() != 0) err_pending++;
            mframe.delete();
            mframe.push_back(d);
        end else if (mframe.size() == 0) begin
            err_pending++;
        end else begin
            mframe.push_back(d);
        end
        if (mframe.size() == FB) begin
            for (int k = 0; k < FB; k++) begin
                load_t e;
                e.pix = PW'(k / 3);
                e.idx = col_code(k % 3);
                e.lvl = mframe[k];
                exp_load.push_back(e);
            end
            model_count = (model_count + 1) % 256;
            frames_total++;
            exp_send.push_back(8'(model_count));
            mframe.delete();
        end
    endfunction

    function automatic void model_clear();
        mframe.delete();
        exp_load.delete();
        exp_send.delete();
        err_pending = 0;
        model_count = 0;
        pend = 1'b0;
    endfunction

    // Controller-side ready generator
    initial begin
        forever begin
            @(posedge clock);
            #1;
            case (rtl_mode)
                0:       ready_to_load = 1'b1;
                1:       ready_to_load = ~ready_to_load;
                2:       ready_to_load = 1'($urandom_range(0, 1));
                default: ready_to_load = 1'b0;
            endcase
            case (rts_mode)
                0:       ready_to_send = 1'b1;
                2:       ready_to_send = 1'($urandom_range(0, 1));
                default: ready_to_send = 1'b0;
            endcase
        end
    end

    // Monitor / scoreboard
    always @(negedge clock) begin
        if (reset_n) begin
            if (pend) begin
                check("frames_sent", {24'd0, frames_sent}, {24'd0, pend_val});
                pend = 1'b0;
            end
            fill_due  = (exp_load.size() == 0) && (exp_send.size() == 0);
            loads_due = (exp_load.size() != 0) && ready_to_load;
            send_due  = (exp_load.size() == 0) && (exp_send.size() != 0) && ready_to_send;
            check("in_ready", {31'd0, in_ready}, {31'd0, fill_due});
            check("load_color", {31'd0, load_color}, {31'd0, loads_due});
            if (load_color && exp_load.size() != 0) begin
                mon_e = exp_load.pop_front();
                check("load_data", {19'd0, pixel_index, color_index, color_level}, {19'd0, mon_e});
                load_cnt++;
            end
            check("send_it", {31'd0, send_it}, {31'd0, send_due});
            if (send_it && send_due) begin
                pend_val = exp_send.pop_front();
                pend = 1'b1;
            end
            check("frame_err", {31'd0, frame_err}, {31'd0, err_pending > 0});
            if (frame_err && err_pending > 0) err_pending--;
        end
    end

    task automatic assert_reset_now();
        reset_n = 1'b0;
        model_clear();
        #1;
        check("rst_load_color", {31'd0, load_color}, 32'd0);
        check("rst_send_it", {31'd0, send_it}, 32'd0);
        check("rst_frames_sent", {24'd0, frames_sent}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check("rst_outs", {19'd0, pixel_index, color_index, color_level}, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        #3;
        assert_reset_now();
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the byte is taken
    task automatic send_byte(input logic sof, input logic [7:0] d, input int gap);
        logic acc;
        logic done;
        repeat (gap) begin
            in_valid = 1'b0;
            in_sof   = 1'($urandom);
            in_data  = 8'($urandom);
            @(posedge clock);
            #1;
        end
        in_valid = 1'b1;
        in_sof   = sof;
        in_data  = d;
        done     = 1'b0;
        for (int c = 0; c < 3000 && !done; c++) begin
            @(negedge clock);
            acc = in_ready;
            @(posedge clock);
            if (acc) begin
                model_accept(sof, d);
                done = 1'b1;
            end
            #1;
        end
        if (!done) begin
            checks++;
            $display("FAIL send_byte_timeout: got no in_ready required in_ready=1");
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic wait_idle();
        logic idle;
        idle = 1'b0;
        for (int c = 0; c < 5000 && !idle; c++) begin
            @(negedge clock);
            idle = (exp_load.size() == 0) && (exp_send.size() == 0) && !pend;
        end
        if (!idle) begin
            checks++;
            $display("FAIL wait_idle_timeout: got pending frame work required none");
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        int ld0;
        int start;
        logic sof;
        logic hit;

        rtl_mode = 0;
        rts_mode = 0;
        do_reset();

        // Directed frame 0x01..0x0F, loads on consecutive cycles then one send
        for (int k = 0; k < FB; k++) send_byte(k == 0, 8'(k + 1), 0);
        for (int i = 0; i < FB; i++) begin
            @(negedge clock);
            check("consec_load", {31'd0, load_color}, 32'd1);
            if (i == 0 || i == 1 || i == FB - 1)
                check("directed_data", {19'd0, pixel_index, color_index, color_level},
                      {19'd0, PW'(i / 3), col_code(i % 3), 8'(i + 1)});
        end
        @(negedge clock);
        check("directed_send", {31'd0, send_it}, 32'd1);
        @(posedge clock);
        #1;
        wait_idle();

        // ready_to_load toggling
        rtl_mode = 1;
        ld0 = load_cnt;
        for (int k = 0; k < FB; k++) send_byte(k == 0, 8'($urandom), 0);
        wait_idle();
        check("toggle_count", load_cnt - ld0, FB);
        rtl_mode = 0;

        // Stray byte after reset, then a clean frame
        do_reset();
        send_byte(1'b0, 8'hAA, 0);
        for (int k = 0; k < FB; k++) send_byte(k == 0, 8'h40 + 8'(k), 1);
        wait_idle();

        // sof in the middle of a frame restarts it
        for (int k = 0; k < 7; k++) send_byte(k == 0, 8'h10 + 8'(k), 0);
        for (int k = 0; k < FB; k++) send_byte(k == 0, 8'h20 + 8'(k), 0);
        wait_idle();

        // ready_to_send held low in SEND
        rts_mode = 3;
        for (int k = 0; k < FB; k++) send_byte(k == 0, 8'($urandom), 0);
        for (int c = 0; c < 200 && exp_load.size() != 0; c++) @(negedge clock);
        repeat (100) begin
            @(negedge clock);
            check("hold_send", {31'd0, send_it}, 32'd0);
        end
        check("hold_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clock);
        #1;
        rts_mode = 0;
        wait_idle();
        @(negedge clock);
        check("after_send_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clock);
        #1;

        // Randomised traffic, long enough to wrap frames_sent
        start = frames_total;
        for (int it = 0; it < 600 && frames_total - start < 258; it++) begin
            rtl_mode = $urandom_range(0, 2);
            rts_mode = ($urandom_range(0, 1) == 1) ? 0 : 2;
            for (int j = 0; j < FB; j++) begin
                sof = (j == 0) || ($urandom_range(0, 39) == 0);
                if (j == 0 && $urandom_range(0, 29) == 0) sof = 1'b0;
                send_byte(sof, 8'($urandom), $urandom_range(0, 2));
            end
        end
        check("random_frames", {31'd0, frames_total - start >= 258}, 32'd1);
        rtl_mode = 0;
        rts_mode = 0;
        wait_idle();

        // Reset in the middle of LOAD
        rtl_mode = 2;
        rts_mode = 3;
        ld0 = load_cnt;
        for (int k = 0; k < FB; k++) send_byte(k == 0, 8'($urandom), 0);
        hit = 1'b0;
        for (int c = 0; c < 300 && !hit; c++) begin
            @(negedge clock);
            hit = load_color && (load_cnt >= ld0 + 3);
        end
        check("midload_reached", {31'd0, hit}, 32'd1);
        #2;
        assert_reset_now();
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        rtl_mode = 0;
        rts_mode = 0;
        repeat (30) @(posedge clock);
        #1;
        wait_idle();
        check("err_drain", err_pending, 0);
        check("load_drain", exp_load.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
